// File: rtl/sol32_memarbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single memory port.
// Alternates grants on contention and aborts transfers that wait too long.

module sol32_memarbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic mem_req,
  input logic fetch_ack,
  input logic data_ack
);

  // Completion pulses are exclusive, single-cycle and never overlap an open request
  a_one_ack:        assert property (@(posedge clk) disable iff (!rst_n) !(fetch_ack && data_ack));
  a_ack_no_req:     assert property (@(posedge clk) disable iff (!rst_n) !((fetch_ack || data_ack) && mem_req));
  a_fetch_ack_once: assert property (@(posedge clk) disable iff (!rst_n) fetch_ack |=> !fetch_ack);
  a_data_ack_once:  assert property (@(posedge clk) disable iff (!rst_n) data_ack |=> !data_ack);

endmodule

module sol32_memarbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error,
  output logic [31:0] error_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic        last_data_r, last_data_s;
  logic [7:0]  wait_cnt_r, wait_cnt_s;
  logic        mem_req_r, mem_req_s;
  logic        mem_we_r, mem_we_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic [31:0] fetch_data_r, fetch_data_s;
  logic        fetch_ack_r, fetch_ack_s;
  logic [31:0] data_rdata_r, data_rdata_s;
  logic        data_ack_r, data_ack_s;
  logic        bus_error_r, bus_error_s;
  logic [31:0] error_addr_r, error_addr_s;

  logic        fetch_ok_s, data_ok_s;
  logic        grant_fetch_s, grant_data_s;
  logic        done_s, timeout_s;

  // Arbitration: a requester still holding its line during its own ack cycle is not re-granted
  always_comb begin
    fetch_ok_s    = fetch_req & ~fetch_ack_r;
    data_ok_s     = data_req & ~data_ack_r;
    grant_data_s  = data_ok_s & (~fetch_ok_s | ~last_data_r);
    grant_fetch_s = fetch_ok_s & ~grant_data_s;
    done_s        = mem_req_r & mem_ack;
    timeout_s     = mem_req_r & ~mem_ack & (wait_cnt_r == WAIT_LAST);
  end

  // Next-state and next-output computation for the transfer FSM
  always_comb begin
    state_s      = state_r;
    last_data_s  = last_data_r;
    wait_cnt_s   = wait_cnt_r;
    mem_req_s    = mem_req_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    fetch_data_s = fetch_data_r;
    fetch_ack_s  = 1'b0;
    data_rdata_s = data_rdata_r;
    data_ack_s   = 1'b0;
    error_addr_s = error_addr_r;
    if (err_clr) begin
      bus_error_s = 1'b0;
    end else begin
      bus_error_s = bus_error_r;
    end

    case (state_r)
      IDLE: begin
        if (grant_data_s) begin
          state_s     = DATA;
          last_data_s = 1'b1;
          wait_cnt_s  = 8'd0;
          mem_req_s   = 1'b1;
          mem_we_s    = data_we;
          mem_addr_s  = data_addr;
          mem_wdata_s = data_wdata;
        end else if (grant_fetch_s) begin
          state_s     = FETCH;
          last_data_s = 1'b0;
          wait_cnt_s  = 8'd0;
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = fetch_addr;
          mem_wdata_s = 32'd0;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH, DATA: begin
        if (done_s) begin
          state_s   = IDLE;
          mem_req_s = 1'b0;
          if (state_r == FETCH) begin
            fetch_ack_s  = 1'b1;
            fetch_data_s = mem_rdata;
          end else begin
            data_ack_s = 1'b1;
            if (!mem_we_r) begin
              data_rdata_s = mem_rdata;
            end else begin
              data_rdata_s = data_rdata_r;
            end
          end
        end else if (timeout_s) begin
          // Abort: the owner still gets its ack, with zero read data
          state_s      = IDLE;
          mem_req_s    = 1'b0;
          bus_error_s  = 1'b1;
          error_addr_s = mem_addr_r;
          if (state_r == FETCH) begin
            fetch_ack_s  = 1'b1;
            fetch_data_s = 32'd0;
          end else begin
            data_ack_s   = 1'b1;
            data_rdata_s = 32'd0;
          end
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_data_r  <= 1'b0;
      wait_cnt_r   <= 8'd0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      fetch_data_r <= 32'd0;
      fetch_ack_r  <= 1'b0;
      data_rdata_r <= 32'd0;
      data_ack_r   <= 1'b0;
      bus_error_r  <= 1'b0;
      error_addr_r <= 32'd0;
    end else begin
      state_r      <= state_s;
      last_data_r  <= last_data_s;
      wait_cnt_r   <= wait_cnt_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      fetch_data_r <= fetch_data_s;
      fetch_ack_r  <= fetch_ack_s;
      data_rdata_r <= data_rdata_s;
      data_ack_r   <= data_ack_s;
      bus_error_r  <= bus_error_s;
      error_addr_r <= error_addr_s;
    end
  end

  assign fetch_data = fetch_data_r;
  assign fetch_ack  = fetch_ack_r;
  assign data_rdata = data_rdata_r;
  assign data_ack   = data_ack_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign bus_error  = bus_error_r;
  assign error_addr = error_addr_r;

  sol32_memarbiter_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req_r),
    .fetch_ack (fetch_ack_r),
    .data_ack  (data_ack_r)
  );

endmodule

// File: tb/tb_sol32_memarbiter.sv
// Bench for sol32_memarbiter: a behavioural memory with programmable ack delay,
// and a transaction-level model predicting grant order, latency, data and errors.

module tb_sol32_memarbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic [31:0] fetch_data;
  logic        fetch_ack;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        bus_error;
  logic [31:0] error_addr;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  int ack_delay = 0;
  bit stray = 1'b0;
  int wcnt = 0;
  logic [31:0] mem [logic [31:0]];

  bit          model_last_data = 1'b0;
  bit          model_err = 1'b0;
  logic [31:0] model_ea = 32'h0;
  logic [31:0] model_fd = 32'h0;
  logic [31:0] model_drd = 32'h0;

  sol32_memarbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_ack(fetch_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_error(bus_error), .error_addr(error_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Memory: acks in the (ack_delay+1)-th request cycle; junk data otherwise
  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt = 0;
      mem_ack = stray;
      mem_rdata = $urandom;
    end else if (wcnt == ack_delay) begin
      mem_ack = 1'b1;
      mem_rdata = mem_rd(mem_addr);
      if (mem_we) mem[mem_addr] = mem_wdata;
      wcnt++;
    end else begin
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      wcnt++;
    end
  end

  task automatic run_txn(input bit gap, input bit do_f, input bit do_d,
                         input logic [31:0] fa, input logic [31:0] da,
                         input logic [31:0] wd, input bit we, input int d);
    int k;
    bit to, first_d, is_d, ewe;
    logic [31:0] ea, ew, exp_rd;
    k = (d + 1 < TO) ? d + 1 : TO;
    to = (d >= TO);
    ack_delay = d;
    if (gap) begin @(posedge clk); #1; end
    fetch_req = do_f; fetch_addr = fa;
    data_req = do_d; data_we = we; data_addr = da; data_wdata = wd;
    first_d = do_d && (!do_f || !model_last_data);
    for (int i = 0; i < int'(do_f) + int'(do_d); i++) begin
      is_d = (i == 0) ? first_d : !first_d;
      ea = is_d ? da : fa;
      ewe = is_d ? we : 1'b0;
      ew = is_d ? wd : 32'h0;
      model_last_data = is_d;
      @(posedge clk); #1;
      for (int c = 1; c <= k; c++) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, fetch_ack, data_ack} !== {1'b1, ewe, ea, ew, 2'b00}) begin
          failures++;
          $display("FAIL mem_if cyc%0d: req=%b we=%b addr=%h wdata=%h acks=%b%b, want req=1 we=%b addr=%h wdata=%h acks=00",
                   c, mem_req, mem_we, mem_addr, mem_wdata, fetch_ack, data_ack, ewe, ea, ew);
        end
        @(posedge clk); #1;
      end
      exp_rd = to ? 32'h0 : mem_rd(ea);
      if (to) begin model_err = 1'b1; model_ea = ea; end
      if (is_d) begin
        if (to || !we) model_drd = exp_rd;
        data_req = 1'b0;
      end else begin
        model_fd = exp_rd;
        fetch_req = 1'b0;
      end
      checks++;
      if ({fetch_ack, data_ack, mem_req} !== {!is_d, is_d, 1'b0}) begin
        failures++;
        $display("FAIL ack: fetch_ack=%b data_ack=%b mem_req=%b, want %b %b 0", fetch_ack, data_ack, mem_req, !is_d, is_d);
      end
      checks++;
      if (fetch_data !== model_fd || data_rdata !== model_drd) begin
        failures++;
        $display("FAIL rdata: fetch_data=%h data_rdata=%h, want %h %h", fetch_data, data_rdata, model_fd, model_drd);
      end
      checks++;
      if (bus_error !== model_err || error_addr !== model_ea) begin
        failures++;
        $display("FAIL error: bus_error=%b error_addr=%h, want %b %h", bus_error, error_addr, model_err, model_ea);
      end
    end
  endtask

  task automatic clear_error();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_err = 1'b0;
    checks++;
    if (bus_error !== 1'b0 || error_addr !== model_ea) begin
      failures++;
      $display("FAIL err_clr: bus_error=%b error_addr=%h, want 0 %h", bus_error, error_addr, model_ea);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_req, mem_we, fetch_ack, data_ack, bus_error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: req/we/facks/dack/err=%b, want 00000", {mem_req, mem_we, fetch_ack, data_ack, bus_error});
    end
    checks++;
    if ({mem_addr, mem_wdata, fetch_data, data_rdata, error_addr} !== 160'h0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h fd=%h drd=%h ea=%h, want all 0", mem_addr, mem_wdata, fetch_data, data_rdata, error_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: mem_req=%b, want 0", mem_req);
    end
  endtask

  task automatic test_arbitration();
    run_txn(1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 32'h55AA, 1'b1, 0);
    run_txn(1'b1, 1'b1, 1'b1, 32'h108, 32'h204, 32'h0, 1'b0, 1);
  endtask

  task automatic test_fetch_basic();
    mem[32'h100] = 32'hDEADBEEF;
    run_txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0);
    checks++;
    if (fetch_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fetch_basic: fetch_data=%h, want deadbeef", fetch_data);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h300, 32'h0, 1'b0, 8);
    checks++;
    if (bus_error !== 1'b1 || error_addr !== 32'h300 || data_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout: bus_error=%b error_addr=%h data_rdata=%h, want 1 300 0", bus_error, error_addr, data_rdata);
    end
    clear_error();
    run_txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h304, 32'h0, 1'b0, TO - 1);
    checks++;
    if (bus_error !== 1'b0 || error_addr !== 32'h300) begin
      failures++;
      $display("FAIL ack_on_timeout: bus_error=%b error_addr=%h, want 0 300", bus_error, error_addr);
    end
    // Clear held high across a timing-out fetch: the timeout must win
    err_clr = 1'b1;
    run_txn(1'b1, 1'b1, 1'b0, 32'h308, 32'h0, 32'h0, 1'b0, 9);
    err_clr = 1'b0;
    clear_error();
  endtask

  task automatic test_hold();
    run_txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h180, 32'h0, 1'b0, 1);
    run_txn(1'b1, 1'b1, 1'b0, 32'h184, 32'h0, 32'h0, 1'b0, 2);
    run_txn(1'b1, 1'b0, 1'b1, 32'h0, 32'h188, 32'h1111_2222, 1'b1, 0);
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({fetch_ack, data_ack, mem_req} !== 3'b000 || fetch_data !== model_fd || data_rdata !== model_drd) begin
        failures++;
        $display("FAIL stray_ack: acks=%b%b req=%b fd=%h drd=%h, want 000 %h %h",
                 fetch_ack, data_ack, mem_req, fetch_data, data_rdata, model_fd, model_drd);
      end
    end
    stray = 1'b0;
  endtask

  task automatic test_reset_mid();
    ack_delay = 50;
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h140;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: mem_req=%b, want 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || fetch_ack !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: mem_req=%b mem_addr=%h fetch_ack=%b, want 0 0 0", mem_req, mem_addr, fetch_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (fetch_ack !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_ack: fetch_ack=%b mem_req=%b, want 0 0", fetch_ack, mem_req);
    end
    @(negedge clk); rst_n = 1'b1;
    model_last_data = 1'b0; model_err = 1'b0; model_ea = 32'h0; model_fd = 32'h0; model_drd = 32'h0;
    run_txn(1'b0, 1'b1, 1'b0, 32'h140, 32'h0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_random();
    int sel;
    logic [31:0] fa, da;
    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 2));
      fa = 32'h400 + ($urandom_range(0, 7) << 2);
      da = 32'h400 + ($urandom_range(0, 7) << 2);
      run_txn(1'b1, sel != 1, sel != 0, fa, da, $urandom, bit'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) clear_error();
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_fetch_basic();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sol32_memarbiter.md
SOL32_MEMARBITER -- requirements
Module: sol32_memarbiter

Interface
REQ-001 The module SHALL have one parameter, TIMEOUT, default 16: the number of cycles MemReq may wait without MemAck before the transfer aborts, with legal range 1..255.
REQ-002 Clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 FetchReq  in  1  instruction fetch request, held high until FetchAck.
REQ-005 FetchAddr  in  32  fetch address, stable while FetchReq is high.
REQ-006 FetchData  out  32  fetched word, valid in the FetchAck cycle and held until the next fetch completes.
REQ-007 FetchAck  out  1  one-cycle completion pulse for a fetch.
REQ-008 DataReq  in  1  load/store request, held high until DataAck.
REQ-009 DataWe  in  1  1 = store, 0 = load; stable while DataReq is high.
REQ-010 DataAddr / DataWData  in  32 / 32  load/store address and store data.
REQ-011 DataRData  out  32  load result, valid in the DataAck cycle and held until the next data transfer completes.
REQ-012 DataAck  out  1  one-cycle completion pulse for a load or store.
REQ-013 MemReq / MemWe  out  1 / 1  memory transfer request and write strobe.
REQ-014 MemAddr / MemWData  out  32 / 32  memory address and write data.
REQ-015 MemRData / MemAck  in  32 / 1  memory read data and completion; MemAck is valid only while MemReq is high.
REQ-016 BusError  out  1  sticky timeout flag.
REQ-017 ErrorAddr  out  32  address of the transfer that timed out.
REQ-018 ErrClr  in  1  synchronous clear for BusError.

Function
REQ-019 The state machine SHALL have exactly three states: IDLE, FETCH and DATA.
REQ-020 In IDLE with only FetchReq high, the next state SHALL be FETCH; with only DataReq high, the next state SHALL be DATA; with neither high, the machine SHALL stay in IDLE.
REQ-021 On simultaneous FetchReq and DataReq in IDLE, the machine SHALL grant the requester that did not receive the previous grant (LastGrant bit, reset value = fetch, so data wins first).
REQ-022 On the granting edge, the block SHALL register MemAddr, MemWData and MemWe from the winning requester (MemWe = 0 and MemWData = 0 for a fetch); MemReq SHALL be high from the following cycle.
REQ-023 MemReq, MemAddr, MemWe and MemWData SHALL stay constant while in FETCH or DATA until the transfer ends.
REQ-024 On an edge with MemReq and MemAck both high, the block SHALL:
- latch MemRData into FetchData (FETCH) or, for a load only, into DataRData (DATA);
- pulse FetchAck or DataAck for exactly one cycle;
- drop MemReq;
- return to IDLE.
REQ-025 Minimum request-to-ack latency SHALL be 2 cycles: request sampled at edge N, MemReq high in cycle N+1, MemAck sampled at edge N+1, Ack high in cycle N+2.
REQ-026 After each transfer the block SHALL spend at least one cycle in IDLE before the next grant.
REQ-027 A wait counter (8 bits) SHALL clear on every grant and increment on each edge in FETCH/DATA where MemAck is low.
REQ-028 When the wait counter reaches TIMEOUT with MemAck still low, the block SHALL:
- drop MemReq;
- pulse the owner's Ack with read data 0;
- set BusError;
- load ErrorAddr with MemAddr;
- return to IDLE.
REQ-029 If MemAck arrives on the same edge the counter would reach TIMEOUT, the ack SHALL win and no error SHALL be recorded.
REQ-030 A requester that drops its request mid-transfer SHALL NOT abort the transfer; its Ack SHALL still pulse.
REQ-031 MemAck while in IDLE SHALL be ignored.
REQ-032 ErrClr SHALL clear BusError on the next edge; a timeout in the same cycle as ErrClr SHALL take precedence and leave BusError set.
REQ-033 ErrorAddr SHALL update only on a timeout.

Reset
REQ-034 While Reset is low, the block SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- set LastGrant to fetch;
- clear the wait counter;
- drive MemReq, MemWe, FetchAck, DataAck and BusError to 0;
- drive MemAddr, MemWData, FetchData, DataRData and ErrorAddr to 0.
REQ-035 A reset asserted mid-transfer SHALL abandon that transfer with no Ack pulse; requests still high after reset release SHALL be arbitrated normally.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Fetch of 0x100, MemAck in the first MemReq cycle with MemRData = 0xDEADBEEF -> FetchAck in cycle N+2, FetchData = 0xDEADBEEF, MemWe = 0 throughout.
- FetchReq and DataReq both high out of reset (store 0x55AA to 0x200) -> data is granted first (MemWe = 1, MemAddr = 0x200); fetch is granted after one IDLE cycle; the next simultaneous pair is granted to data again.
- TIMEOUT = 4, MemAck never asserted for a load at 0x300 -> MemReq drops after 4 wait cycles, DataAck pulses with DataRData = 0, BusError = 1, ErrorAddr = 0x300; ErrClr then clears BusError.
- MemAck arriving exactly on the timeout edge -> normal completion, BusError stays 0.
- Reset pulled low two cycles into a fetch -> MemReq drops asynchronously, no FetchAck; after release with FetchReq still high, a fresh fetch completes.
- Load followed by fetch -> DataRData holds the load value across the fetch; FetchData holds its old value across the load.
